// File: rtl/operand_bypass_unit_pkg.sv
// Shared types for the decode-stage operand bypass: operand/register types,
// forwarding records and the hazard FSM state encoding.
package operand_bypass_unit_pkg;
  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int PERF_W = 32;
  localparam int NSRC   = 2;
  localparam int RA_W   = $clog2(NREG);

  typedef logic [XLEN-1:0] word_t;
  typedef logic [RA_W-1:0] creg_addr_t;
  localparam creg_addr_t ZERO_REG = '0;

  typedef struct packed {
    logic       valid;
    creg_addr_t dst;
    word_t      data;
  } fwd_t;

  typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_WAIT} bypass_state_e;

  function automatic logic fwd_hit(input fwd_t f, input creg_addr_t rs);
    return f.valid && (f.dst == rs);
  endfunction
endpackage

// File: rtl/operand_bypass_unit_if.sv
// ID-stage bundle: regfile read data and forwarding records in, resolved
// operands and stall controls out.
interface operand_bypass_unit_if;
  import operand_bypass_unit_pkg::*;
  logic              id_valid;
  creg_addr_t        rs1, rs2;
  word_t             rf_rdata1, rf_rdata2;
  fwd_t              ex_fwd, mem_fwd, wb_fwd;
  logic              ex_is_load, mem_is_load, mem_data_ok;
  word_t             src1, src2;
  logic              stall_id, bubble_ex, stall_all;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output id_valid, rs1, rs2, rf_rdata1, rf_rdata2, ex_fwd, mem_fwd, wb_fwd,
           ex_is_load, mem_is_load, mem_data_ok,
    input  src1, src2, stall_id, bubble_ex, stall_all, stall_cnt
  );
  modport slave (
    input  id_valid, rs1, rs2, rf_rdata1, rf_rdata2, ex_fwd, mem_fwd, wb_fwd,
           ex_is_load, mem_is_load, mem_data_ok,
    output src1, src2, stall_id, bubble_ex, stall_all, stall_cnt
  );
endinterface

// File: rtl/operand_bypass_unit_operand_mux.sv
// Single-source operand select: zero reg, held value, then youngest forward
// stage first, regfile last.
module operand_mux
  import operand_bypass_unit_pkg::*;
(
  input  creg_addr_t rs,
  input  logic       hold_vld,
  input  word_t      hold_data,
  input  fwd_t       ex_fwd,
  input  logic       ex_is_load,
  input  fwd_t       mem_fwd,
  input  fwd_t       wb_fwd,
  input  word_t      rf_rdata,
  output word_t      src,
  output logic       wb_sel
);
  logic ex_hit, mem_hit, wb_hit;

  assign ex_hit  = fwd_hit(ex_fwd, rs);
  assign mem_hit = fwd_hit(mem_fwd, rs);
  assign wb_hit  = fwd_hit(wb_fwd, rs);

  always_comb begin
    src    = rf_rdata;
    wb_sel = 1'b0;
    if (rs == ZERO_REG)          src = '0;
    else if (hold_vld)           src = hold_data;
    else if (ex_hit && !ex_is_load) src = ex_fwd.data;
    else if (mem_hit)            src = mem_fwd.data;
    else if (wb_hit) begin
      src    = wb_fwd.data;
      // a pending load to the same reg makes this value stale; never hold it
      wb_sel = !ex_hit;
    end
  end
endmodule

// File: rtl/operand_bypass_unit.sv
// Decode-stage operand resolver: forwarding select per source, load-use and
// memory-wait hazard FSM, hold registers for values lost during freezes.
module operand_bypass_unit
  import operand_bypass_unit_pkg::*;
(
  input logic clk,
  input logic reset,
  operand_bypass_unit_if.slave bp
);
  bypass_state_e             state_q, state_d;
  logic [NSRC-1:0]           hold_vld_q, hold_vld_d;
  creg_addr_t [NSRC-1:0]     hold_rs_q, hold_rs_d;
  word_t [NSRC-1:0]          hold_data_q, hold_data_d;
  logic [PERF_W-1:0]         stall_cnt_q, stall_cnt_d;

  creg_addr_t [NSRC-1:0]     rs;
  word_t [NSRC-1:0]          rf_rdata, src;
  logic [NSRC-1:0]           hold_use, wb_sel;
  logic stall_id, bubble_ex, stall_all, any_stall, lu_hazard, mem_wait_req;

  assign rs       = {bp.rs2, bp.rs1};
  assign rf_rdata = {bp.rf_rdata2, bp.rf_rdata1};

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    // a hold is only meaningful for the register it was captured for
    assign hold_use[i] = hold_vld_q[i] && (hold_rs_q[i] == rs[i]);
    operand_mux u_mux (
      .rs        (rs[i]),
      .hold_vld  (hold_use[i]),
      .hold_data (hold_data_q[i]),
      .ex_fwd    (bp.ex_fwd),
      .ex_is_load(bp.ex_is_load),
      .mem_fwd   (bp.mem_fwd),
      .wb_fwd    (bp.wb_fwd),
      .rf_rdata  (rf_rdata[i]),
      .src       (src[i]),
      .wb_sel    (wb_sel[i])
    );
  end

  assign mem_wait_req = bp.mem_is_load && bp.mem_fwd.valid && !bp.mem_data_ok;
  assign lu_hazard    = bp.id_valid && bp.ex_is_load && bp.ex_fwd.valid &&
                        (bp.ex_fwd.dst != ZERO_REG) &&
                        ((bp.ex_fwd.dst == bp.rs1) || (bp.ex_fwd.dst == bp.rs2));

  always_comb begin
    state_d   = state_q;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    stall_all = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_wait_req) begin
          state_d   = MEM_WAIT;
          stall_all = 1'b1;
        end else if (lu_hazard) begin
          state_d   = LU_BUBBLE;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end
      end
      LU_BUBBLE: state_d = RUN;
      MEM_WAIT: begin
        if (bp.mem_data_ok) state_d = RUN;
        else                stall_all = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (reset) begin
      stall_id  = 1'b0;
      bubble_ex = 1'b0;
      stall_all = 1'b0;
    end
  end

  assign any_stall = stall_id || bubble_ex || stall_all;

  always_comb begin
    hold_vld_d  = '0;
    hold_rs_d   = hold_rs_q;
    hold_data_d = hold_data_q;
    for (int i = 0; i < NSRC; i++) begin
      if (any_stall) begin
        if (hold_use[i]) begin
          hold_vld_d[i] = 1'b1;
        end else if (wb_sel[i]) begin
          hold_vld_d[i]  = 1'b1;
          hold_rs_d[i]   = rs[i];
          hold_data_d[i] = src[i];
        end
      end
    end
  end

  assign stall_cnt_d = stall_cnt_q + PERF_W'(any_stall);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      hold_vld_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_vld_q  <= hold_vld_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_rs_q   <= hold_rs_d;
    hold_data_q <= hold_data_d;
  end

  assign bp.src1      = src[0];
  assign bp.src2      = src[1];
  assign bp.stall_id  = stall_id;
  assign bp.bubble_ex = bubble_ex;
  assign bp.stall_all = stall_all;
  assign bp.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_operand_bypass_unit.sv
// Directed bench for operand_bypass_unit: forwarding priority, load-use bubble,
// memory wait, hold across freeze, reset mid-stall.
module tb_operand_bypass_unit;
  import operand_bypass_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  operand_bypass_unit_if bp();
  operand_bypass_unit dut (.clk(clk), .reset(reset), .bp(bp));

  always #5 clk = ~clk;

  function automatic fwd_t mk(input logic v, input creg_addr_t d, input word_t x);
    fwd_t f;
    f.valid = v; f.dst = d; f.data = x;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bp.id_valid = 1'b0; bp.rs1 = '0; bp.rs2 = '0;
    bp.rf_rdata1 = '0; bp.rf_rdata2 = '0;
    bp.ex_fwd = mk(1'b0, '0, '0); bp.mem_fwd = mk(1'b0, '0, '0); bp.wb_fwd = mk(1'b0, '0, '0);
    bp.ex_is_load = 1'b0; bp.mem_is_load = 1'b0; bp.mem_data_ok = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; clr();
    @(posedge clk); @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall_all", bp.stall_all, 0);
    chk("rst_stall_id", bp.stall_id, 0);
    chk("rst_cnt", bp.stall_cnt, 0);
    reset = 1'b0;

    // forwarding priority
    bp.rs1 = 5'd5; bp.ex_fwd = mk(1, 5'd5, 64'h11); bp.mem_fwd = mk(1, 5'd5, 64'h22);
    #1 chk("t1_ex_wins", bp.src1, 64'h11);
    bp.ex_fwd = mk(0, 5'd5, 64'h11); bp.wb_fwd = mk(1, 5'd5, 64'h33);
    #1 chk("t1_mem_over_wb", bp.src1, 64'h22);
    bp.mem_fwd = mk(0, 5'd5, 64'h22);
    #1 chk("t1_wb_only", bp.src1, 64'h33);

    // zero reg and regfile fallback
    clr(); bp.rs2 = 5'd0; bp.ex_fwd = mk(1, 5'd0, 64'hFF); bp.rf_rdata2 = 64'h5A;
    #1 chk("t2_zero_reg", bp.src2, 0);
    bp.rs2 = 5'd3; bp.rf_rdata2 = 64'hAB;
    #1 chk("t2_regfile", bp.src2, 64'hAB);

    // id_valid low: no load-use stall
    clr(); bp.ex_is_load = 1; bp.ex_fwd = mk(1, 5'd7, 64'hDEAD); bp.rs1 = 5'd7;
    #1 chk("idv0_no_stall", bp.stall_id, 0);

    // load-use
    @(negedge clk);
    bp.id_valid = 1; bp.rf_rdata1 = 64'h77;
    #1 chk("t3_stall_id", bp.stall_id, 1);
    chk("t3_bubble", bp.bubble_ex, 1);
    chk("t3_no_load_data", bp.src1, 64'h77);
    @(negedge clk);
    bp.ex_is_load = 0; bp.ex_fwd = mk(0, '0, '0);
    bp.mem_fwd = mk(1, 5'd7, 64'h55); bp.mem_is_load = 1; bp.mem_data_ok = 1;
    #1 chk("t3_src1_mem", bp.src1, 64'h55);
    chk("t3_stall_low", bp.stall_id, 0);
    chk("t3_bubble_low", bp.bubble_ex, 0);
    chk("t3_cnt", bp.stall_cnt, 1);

    // memory wait, three cycles
    do_reset();
    bp.mem_is_load = 1; bp.mem_fwd = mk(1, 5'd3, '0); bp.mem_data_ok = 0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t4_stall_all", bp.stall_all, 1);
      @(negedge clk);
    end
    bp.mem_data_ok = 1;
    #1 chk("t4_release", bp.stall_all, 0);
    chk("t4_cnt", bp.stall_cnt, 3);
    @(negedge clk); clr();
    #1 chk("t4_cnt_hold", bp.stall_cnt, 3);

    // hold across freeze
    bp.mem_is_load = 1; bp.mem_fwd = mk(1, 5'd4, '0); bp.mem_data_ok = 0;
    bp.wb_fwd = mk(1, 5'd9, 64'h99); bp.rs1 = 5'd9; bp.rf_rdata1 = 64'h01;
    #1 chk("t5_wb_sel", bp.src1, 64'h99);
    chk("t5_stall", bp.stall_all, 1);
    @(negedge clk); bp.wb_fwd = mk(0, '0, '0);
    #1 chk("t5_held1", bp.src1, 64'h99);
    @(negedge clk);
    #1 chk("t5_held2", bp.src1, 64'h99);
    chk("t5_stall2", bp.stall_all, 1);
    @(negedge clk); bp.mem_data_ok = 1;
    #1 chk("t5_held_release", bp.src1, 64'h99);
    chk("t5_unstall", bp.stall_all, 0);
    @(negedge clk); bp.mem_is_load = 0; bp.mem_fwd = mk(0, '0, '0);
    #1 chk("t5_hold_cleared", bp.src1, 64'h01);

    // reset in MEM_WAIT
    bp.mem_is_load = 1; bp.mem_fwd = mk(1, 5'd2, '0); bp.mem_data_ok = 0;
    @(negedge clk);
    #1 chk("t6_in_wait", bp.stall_all, 1);
    reset = 1'b1;
    #1 chk("t6_rst_gate", bp.stall_all, 0);
    @(negedge clk);
    reset = 1'b0; bp.mem_is_load = 0; bp.mem_fwd = mk(0, '0, '0);
    #1 chk("t6_state_run", bp.stall_all, 0);
    chk("t6_stall_id", bp.stall_id, 0);
    chk("t6_bubble", bp.bubble_ex, 0);
    chk("t6_cnt", bp.stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
